// File: rtl/flag_pkg.sv
// Shared types and constants for the condition-flag hazard controller.
package flag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR1  = 2'd1,
        ST_WRM  = 2'd2
    } flag_state_e;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned FLAG_W  = 4;

    // Flag bit positions inside a {zero, neg, overflow, carry_out} vector
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    // Counter width for a MUL_LAT-cycle writer; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned mul_lat);
        return (mul_lat <= 2) ? 1 : $clog2(mul_lat);
    endfunction

endpackage

// File: rtl/D_FF.sv
// Generic register with asynchronous active-high reset to a fixed value.
module D_FF #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/flag_lat_counter.sv
// Loadable down-counter tracking the remaining EX cycles of a multi-cycle flag writer.
module flag_lat_counter
    import flag_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int unsigned                  CNT_W    = cnt_width(MUL_LAT);
    localparam logic [CNT_W-1:0]             LOAD_VAL = CNT_W'(MUL_LAT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Any cycle that neither loads nor decrements parks the counter at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux2to1.sv
// Two-input word multiplexer; i_sel=1 picks i_d1.
module mux2to1 #(
    parameter int unsigned W = 1
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/flag_ctrl.sv
// Flag-hazard controller: gates flag register writes, forwards live ALU flags
// to B.cond in ID, and stalls IF/ID while a multi-cycle flag writer holds EX.
module flag_ctrl
    import flag_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_setflags,
    input  logic              id_multi,
    input  logic              ex_flush,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [FLAG_W-1:0] flag_q,
    output logic              stall,
    output logic              flag_en,
    output logic [FLAG_W-1:0] bcond_flags,
    output logic              ex_busy
);

    localparam logic [STATE_W-1:0] S_IDLE = ST_IDLE;
    localparam logic [STATE_W-1:0] S_WR1  = ST_WR1;
    localparam logic [STATE_W-1:0] S_WRM  = ST_WRM;

    if (MUL_LAT < 2) begin : g_bad_lat
        $error("flag_ctrl: MUL_LAT must be at least 2");
    end

    logic [STATE_W-1:0] w_state_q;
    logic [STATE_W-1:0] w_state_d;
    logic               w_cnt_load;
    logic               w_cnt_zero;
    logic               w_in_wr1;
    logic               w_in_wrm;
    logic               w_id_wr;

    D_FF #(
        .W       (STATE_W),
        .RST_VAL (S_IDLE)
    ) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .d     (w_state_d),
        .q     (w_state_q)
    );

    flag_lat_counter #(
        .MUL_LAT (MUL_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_cnt_load),
        .i_dec  (stall),
        .o_zero (w_cnt_zero)
    );

    assign w_in_wr1 = (w_state_q == S_WR1);
    assign w_in_wrm = (w_state_q == S_WRM);
    assign w_id_wr  = id_valid && id_setflags;

    // A flush squashes the writer in EX, so it can neither write nor hold ID
    assign flag_en = !ex_flush && (w_in_wr1 || (w_in_wrm && w_cnt_zero));
    assign stall   = w_in_wrm && !w_cnt_zero && !ex_flush;
    assign ex_busy = (w_state_q != S_IDLE);

    always_comb begin
        w_state_d  = S_IDLE;
        w_cnt_load = 1'b0;
        if (ex_flush) begin
            w_state_d = S_IDLE;
        end else if (stall) begin
            w_state_d = S_WRM;
        end else if (w_id_wr && id_multi) begin
            w_state_d  = S_WRM;
            w_cnt_load = 1'b1;
        end else if (w_id_wr) begin
            w_state_d = S_WR1;
        end
    end

    mux2to1 #(
        .W (FLAG_W)
    ) u_bcond_mux (
        .i_sel (flag_en),
        .i_d0  (flag_q),
        .i_d1  (alu_flags),
        .o_y   (bcond_flags)
    );

endmodule

// File: tb/tb_flag_ctrl.sv
// Self-checking bench for flag_ctrl: per-cycle vector table fed through a scoreboard queue.
module tb_flag_ctrl;

    localparam int unsigned MUL_LAT = 3;

    typedef struct {
        logic       v;
        logic       s;
        logic       m;
        logic       fl;
        logic [3:0] alu;
        logic       e_stall;
        logic       e_en;
        logic [3:0] e_bc;
        logic       e_busy;
        logic [3:0] e_fq;
        int         idx;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic       id_setflags;
    logic       id_multi;
    logic       ex_flush;
    logic [3:0] alu_flags;
    logic [3:0] flag_q;
    logic       stall;
    logic       flag_en;
    logic [3:0] bcond_flags;
    logic       ex_busy;

    int n_checks;
    int n_fail;
    int row_no;

    vec_t tbl[$];
    vec_t sb[$];

    flag_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_setflags (id_setflags),
        .id_multi    (id_multi),
        .ex_flush    (ex_flush),
        .alu_flags   (alu_flags),
        .flag_q      (flag_q),
        .stall       (stall),
        .flag_en     (flag_en),
        .bcond_flags (bcond_flags),
        .ex_busy     (ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment flag register (no reset), written when the controller enables it
    always @(posedge clk) begin
        if (flag_en) flag_q <= alu_flags;
    end

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t e);
        chk("stall",       e.idx, 4'(stall),   4'(e.e_stall));
        chk("flag_en",     e.idx, 4'(flag_en), 4'(e.e_en));
        chk("bcond_flags", e.idx, bcond_flags, e.e_bc);
        chk("ex_busy",     e.idx, 4'(ex_busy), 4'(e.e_busy));
        chk("flag_q",      e.idx, flag_q,      e.e_fq);
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_vec(e);
        end
    end

    function automatic vec_t mk(input logic v, input logic s, input logic m, input logic fl,
                                input logic [3:0] alu, input logic st, input logic en,
                                input logic [3:0] bc, input logic bz, input logic [3:0] fq);
        vec_t r;
        r.v = v; r.s = s; r.m = m; r.fl = fl; r.alu = alu;
        r.e_stall = st; r.e_en = en; r.e_bc = bc; r.e_busy = bz; r.e_fq = fq;
        r.idx = 0;
        return r;
    endfunction

    task automatic apply(input vec_t r);
        @(posedge clk);
        #1;
        id_valid    = r.v;
        id_setflags = r.s;
        id_multi    = r.m;
        ex_flush    = r.fl;
        alu_flags   = r.alu;
        r.idx       = row_no;
        row_no++;
        sb.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        row_no      = 0;
        reset       = 1'b1;
        id_valid    = 1'b0;
        id_setflags = 1'b0;
        id_multi    = 1'b0;
        ex_flush    = 1'b0;
        alu_flags   = 4'b0000;
        flag_q      = 4'b0000;

        //                v     s     m     fl    alu      st    en    bc       bz    fq
        // ADDS then B.cond
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b1000));
        // MULS then B.cond held by stall
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b1000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, 4'b0011, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 1'b0, 4'b0011));
        // SUBS, SUBS back-to-back
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 1'b0, 4'b0011));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0011));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 4'b1001, 1'b1, 4'b0100));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1001, 1'b0, 4'b1001));
        // SUBS writes 0101, MULS flushed at cnt=1
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1001, 1'b0, 4'b1001));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b1, 4'b0101, 1'b1, 4'b1001));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0101, 1'b1, 4'b0101));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0101, 1'b1, 4'b0101));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0101, 1'b0, 4'b0101));
        // MULS flushed at cnt=0: write suppressed
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0101, 1'b0, 4'b0101));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0101, 1'b1, 4'b0101));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0101, 1'b1, 4'b0101));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 4'b0101, 1'b1, 4'b0101));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 4'b0101, 1'b0, 4'b0101));
        // SUBS writes 0010, then non-flag ADD; id_multi without setflags is ignored
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0101, 1'b0, 4'b0101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 4'b0101));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010));

        // Reset state, asserted asynchronously before any clock edge
        #3;
        chk("rst_stall",   -1, 4'(stall),   4'b0000);
        chk("rst_flag_en", -1, 4'(flag_en), 4'b0000);
        chk("rst_busy",    -1, 4'(ex_busy), 4'b0000);
        chk("rst_bcond",   -1, bcond_flags, 4'b0000);
        #4;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Async reset mid-WRM with cnt=1, then a full MULS restart
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010));
        @(posedge clk);
        #1;
        id_valid  = 1'b0;
        alu_flags = 4'b0111;
        #1;
        chk("pre_rst_stall", -2, 4'(stall), 4'b0001);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall",   -2, 4'(stall),   4'b0000);
        chk("mid_rst_flag_en", -2, 4'(flag_en), 4'b0000);
        chk("mid_rst_busy",    -2, 4'(ex_busy), 4'b0000);
        chk("mid_rst_bcond",   -2, bcond_flags, 4'b0010);
        @(negedge clk);
        #1;
        reset = 1'b0;
        apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1, 4'b1100, 1'b1, 4'b0010));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1100, 1'b0, 4'b1100));

        for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d scoreboard entries left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
